rtp_audio_depacketizer: RTL and testbench

Receive-side counterpart to the RTP audio packetizer. It consumes UDP payload bytes from the Ethernet UDP core (udp_rec_* interface), validates the 12-byte RTP header, and unpacks 16-bit big-endian audio samples into a jitter FIFO. It feeds the codec playback path, `mywav`, through the `wav_rden`/`wav_out_data` pull interface, with prefill and underflow handling.

---
 rtl/rtp_audio_depacketizer.sv | 192 +++++++++++++++++++
 tb/tb_rtp_audio_depacketizer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rtp_audio_depacketizer.sv
// rtl/rtp_audio_depacketizer.sv - RTP audio depacketizer: header check, sample unpack, jitter FIFO, playback pull
module rtp_audio_depacketizer #(
    parameter logic [31:0] SSRC       = 32'h12345678,
    parameter int          FIFO_DEPTH = 1024,
    parameter int          PREFILL    = 480
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          udp_rec_data_valid,
    input  logic [7:0]                    udp_rec_rdata,
    input  logic [15:0]                   udp_rec_data_length,
    input  logic                          wav_rden,
    output logic [15:0]                   wav_out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          playing,
    output logic [15:0]                   pkt_ok_cnt,
    output logic [15:0]                   pkt_drop_cnt,
    output logic [15:0]                   seq_err_cnt,
    output logic [15:0]                   underflow_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HDR     = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_DROP    = 2'd3;

    logic [1:0]    state;
    logic          valid_d;
    logic [3:0]    bcnt;
    logic [1:0]    ver_r;
    logic [15:0]   seq_r;
    logic [15:0]   exp_seq;
    logic          seq_valid;
    logic [23:0]   ssrc_r;
    logic [15:0]   words_r;
    logic [15:0]   wcnt;
    logic          phase;
    logic [7:0]    hi_r;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [15:0]   mem [FIFO_DEPTH];

    logic [15:0]   len_m12;
    logic [15:0]   words_c;
    logic          no_room;
    logic [31:0]   ssrc_full;
    logic          hdr_ok;
    logic          wr_en;
    logic [15:0]   wr_data;
    logic          rd_en;
    logic          underflow;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        len_m12   = udp_rec_data_length - 16'd12;
        words_c   = len_m12 >> 1;
        no_room   = (udp_rec_data_length < 16'd12) ||
                    (int'(words_c) > FIFO_DEPTH - int'(fifo_level));
        ssrc_full = {ssrc_r, udp_rec_rdata};
        hdr_ok    = (ver_r == 2'b10) && (ssrc_full == SSRC);
        wr_en     = (state == S_PAYLOAD) && udp_rec_data_valid && phase;
        wr_data   = {hi_r, udp_rec_rdata};
        rd_en     = wav_rden && playing && (fifo_level != '0);
        underflow = wav_rden && playing && (fifo_level == '0);
    end

    // valid_d resets high so a packet already in flight at reset release is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            valid_d      <= 1'b1;
            bcnt         <= '0;
            ver_r        <= '0;
            seq_r        <= '0;
            exp_seq      <= '0;
            seq_valid    <= 1'b0;
            ssrc_r       <= '0;
            words_r      <= '0;
            wcnt         <= '0;
            phase        <= 1'b0;
            hi_r         <= '0;
            pkt_ok_cnt   <= '0;
            pkt_drop_cnt <= '0;
            seq_err_cnt  <= '0;
        end else begin
            valid_d <= udp_rec_data_valid;
            case (state)
                S_IDLE: begin
                    if (udp_rec_data_valid && !valid_d) begin
                        ver_r   <= udp_rec_rdata[7:6];
                        words_r <= words_c;
                        if (no_room) begin
                            state        <= S_DROP;
                            pkt_drop_cnt <= sat_inc(pkt_drop_cnt);
                        end else begin
                            state <= S_HDR;
                            bcnt  <= 4'd1;
                        end
                    end
                end
                S_HDR: begin
                    if (!udp_rec_data_valid) begin
                        state        <= S_IDLE;
                        pkt_drop_cnt <= sat_inc(pkt_drop_cnt);
                    end else begin
                        bcnt <= bcnt + 4'd1;
                        case (bcnt)
                            4'd2:                seq_r[15:8] <= udp_rec_rdata;
                            4'd3:                seq_r[7:0]  <= udp_rec_rdata;
                            4'd8, 4'd9, 4'd10:   ssrc_r      <= {ssrc_r[15:0], udp_rec_rdata};
                            4'd11: begin
                                if (!hdr_ok) begin
                                    state        <= S_DROP;
                                    pkt_drop_cnt <= sat_inc(pkt_drop_cnt);
                                end else begin
                                    pkt_ok_cnt <= sat_inc(pkt_ok_cnt);
                                    if (seq_valid && (seq_r != exp_seq))
                                        seq_err_cnt <= sat_inc(seq_err_cnt);
                                    exp_seq   <= seq_r + 16'd1;
                                    seq_valid <= 1'b1;
                                    wcnt      <= '0;
                                    phase     <= 1'b0;
                                    state     <= (words_r == 16'd0) ? S_IDLE : S_PAYLOAD;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_PAYLOAD: begin
                    if (!udp_rec_data_valid) begin
                        state <= S_IDLE;
                    end else if (!phase) begin
                        hi_r  <= udp_rec_rdata;
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        wcnt  <= wcnt + 16'd1;
                        if (wcnt + 16'd1 == words_r)
                            state <= S_IDLE;
                    end
                end
                default: begin
                    if (!udp_rec_data_valid)
                        state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            playing       <= 1'b0;
            wav_out_data  <= '0;
            underflow_cnt <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: ;
            endcase
            if (wav_rden)
                wav_out_data <= rd_en ? mem[rd_ptr] : 16'd0;
            // an underflow stops playback until the FIFO prefills again
            if (underflow) begin
                playing       <= 1'b0;
                underflow_cnt <= sat_inc(underflow_cnt);
            end else if (int'(fifo_level) >= PREFILL) begin
                playing <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rtp_audio_depacketizer.sv
// tb/tb_rtp_audio_depacketizer.sv - directed table-driven bench for rtp_audio_depacketizer
`timescale 1ns/1ps
module tb_rtp_audio_depacketizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        udp_rec_data_valid;
    logic [7:0]  udp_rec_rdata;
    logic [15:0] udp_rec_data_length;
    logic        wav_rden;
    logic [15:0] wav_out_data;
    logic [10:0] fifo_level;
    logic        playing;
    logic [15:0] pkt_ok_cnt;
    logic [15:0] pkt_drop_cnt;
    logic [15:0] seq_err_cnt;
    logic [15:0] underflow_cnt;

    int checks   = 0;
    int failures = 0;
    logic [15:0] q[$];

    localparam logic [31:0] GOOD = 32'h12345678;
    localparam logic [31:0] BAD  = 32'h12345679;

    always #5 clk = ~clk;

    rtp_audio_depacketizer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .udp_rec_data_valid  (udp_rec_data_valid),
        .udp_rec_rdata       (udp_rec_rdata),
        .udp_rec_data_length (udp_rec_data_length),
        .wav_rden            (wav_rden),
        .wav_out_data        (wav_out_data),
        .fifo_level          (fifo_level),
        .playing             (playing),
        .pkt_ok_cnt          (pkt_ok_cnt),
        .pkt_drop_cnt        (pkt_drop_cnt),
        .seq_err_cnt         (seq_err_cnt),
        .underflow_cnt       (underflow_cnt)
    );

    typedef struct {
        int          len;
        logic [7:0]  b0;
        logic [15:0] seq;
        logic [31:0] ssrc;
        logic [15:0] base;
        bit          accept;
        int          ok;
        int          drop;
        int          serr;
        int          level;
        int          play;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] pkt_byte(input int i, input logic [7:0] b0, input logic [15:0] seq,
                                            input logic [31:0] ssrc, input logic [15:0] base);
        logic [15:0] s;
        if (i == 0) return b0;
        if (i == 1) return 8'h60;
        if (i == 2) return seq[15:8];
        if (i == 3) return seq[7:0];
        if (i < 8)  return 8'hA5;
        if (i < 12) return ssrc[8*(11-i) +: 8];
        s = base + 16'((i - 12) / 2);
        return (((i - 12) % 2) == 0) ? s[15:8] : s[7:0];
    endfunction

    task automatic send(input int len, input int nsend, input logic [7:0] b0, input logic [15:0] seq,
                        input logic [31:0] ssrc, input logic [15:0] base);
        for (int i = 0; i < nsend; i++) begin
            udp_rec_data_valid  = 1'b1;
            udp_rec_data_length = 16'(len);
            udp_rec_rdata       = pkt_byte(i, b0, seq, ssrc, base);
            @(posedge clk); #1;
        end
        udp_rec_data_valid = 1'b0;
        udp_rec_rdata      = 8'h00;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic push_samples(input logic [15:0] base, input int n);
        for (int k = 0; k < n; k++) q.push_back(base + 16'(k));
    endtask

    task automatic rd_chk(input string name);
        logic [15:0] exp;
        exp = (q.size() > 0) ? q.pop_front() : 16'd0;
        wav_rden = 1'b1;
        @(posedge clk); #1;
        wav_rden = 1'b0;
        chk(name, int'(wav_out_data), int'(exp));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out"},   int'(wav_out_data),  0);
        chk({tag, "_level"}, int'(fifo_level),    0);
        chk({tag, "_play"},  int'(playing),       0);
        chk({tag, "_ok"},    int'(pkt_ok_cnt),    0);
        chk({tag, "_drop"},  int'(pkt_drop_cnt),  0);
        chk({tag, "_serr"},  int'(seq_err_cnt),   0);
        chk({tag, "_uflow"}, int'(underflow_cnt), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          len  b0     seq      ssrc  base     acc ok drop serr level play
        vecs[0]  = '{972, 8'h80, 16'd5,    BAD,  16'h0001, 0, 0, 1, 0, 0,    0};
        vecs[1]  = '{972, 8'h80, 16'd5,    GOOD, 16'h0001, 1, 1, 1, 0, 480,  1};
        vecs[2]  = '{12,  8'h80, 16'd6,    GOOD, 16'h0000, 1, 2, 1, 0, 480,  1};
        vecs[3]  = '{12,  8'h80, 16'd8,    GOOD, 16'h0000, 1, 3, 1, 1, 480,  1};
        vecs[4]  = '{13,  8'h80, 16'hFFFF, GOOD, 16'h0000, 1, 4, 1, 2, 480,  1};
        vecs[5]  = '{12,  8'h80, 16'h0000, GOOD, 16'h0000, 1, 5, 1, 2, 480,  1};
        vecs[6]  = '{11,  8'h80, 16'd1,    GOOD, 16'h0000, 0, 5, 2, 2, 480,  1};
        vecs[7]  = '{972, 8'h40, 16'd1,    GOOD, 16'h0900, 0, 5, 3, 2, 480,  1};
        vecs[8]  = '{852, 8'h80, 16'd1,    GOOD, 16'h1000, 1, 6, 3, 2, 900,  1};
        vecs[9]  = '{972, 8'h80, 16'd2,    GOOD, 16'h5000, 0, 6, 4, 2, 900,  1};
        vecs[10] = '{252, 8'h80, 16'd2,    GOOD, 16'h2000, 1, 7, 4, 2, 1020, 1};
        vecs[11] = '{20,  8'h80, 16'd3,    GOOD, 16'h3000, 1, 8, 4, 2, 1024, 1};
        vecs[12] = '{14,  8'h80, 16'd4,    GOOD, 16'h4000, 0, 8, 5, 2, 1024, 1};

        rst_n = 1'b0;
        udp_rec_data_valid  = 1'b0;
        udp_rec_rdata       = 8'h00;
        udp_rec_data_length = 16'd0;
        wav_rden            = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[v]) begin
            send(vecs[v].len, vecs[v].len, vecs[v].b0, vecs[v].seq, vecs[v].ssrc, vecs[v].base);
            if (vecs[v].accept) push_samples(vecs[v].base, (vecs[v].len - 12) / 2);
            chk($sformatf("v%0d_ok", v),    int'(pkt_ok_cnt),   vecs[v].ok);
            chk($sformatf("v%0d_drop", v),  int'(pkt_drop_cnt), vecs[v].drop);
            chk($sformatf("v%0d_serr", v),  int'(seq_err_cnt),  vecs[v].serr);
            chk($sformatf("v%0d_level", v), int'(fifo_level),   vecs[v].level);
            chk($sformatf("v%0d_play", v),  int'(playing),      vecs[v].play);
        end

        for (int i = 0; i < 1024; i++) rd_chk("drain_data");
        chk("drain_level", int'(fifo_level), 0);
        chk("drain_play", int'(playing), 1);

        rd_chk("uflow_data");
        chk("uflow_cnt", int'(underflow_cnt), 1);
        chk("uflow_play", int'(playing), 0);
        rd_chk("idle_rd_data");
        chk("idle_rd_uflow", int'(underflow_cnt), 1);

        send(972, 972, 8'h80, 16'd4, GOOD, 16'h0100);
        push_samples(16'h0100, 480);
        chk("reprefill_play", int'(playing), 1);
        chk("reprefill_level", int'(fifo_level), 480);
        chk("reprefill_serr", int'(seq_err_cnt), 2);
        for (int i = 0; i < 10; i++) rd_chk("partial_data");
        chk("partial_level", int'(fifo_level), 470);

        send(972, 6, 8'h80, 16'd5, GOOD, 16'h0000);
        chk("trunc_hdr_drop", int'(pkt_drop_cnt), 6);
        chk("trunc_hdr_level", int'(fifo_level), 470);

        send(972, 12 + 101, 8'h80, 16'd5, GOOD, 16'h0700);
        push_samples(16'h0700, 50);
        chk("trunc_pl_ok", int'(pkt_ok_cnt), 10);
        chk("trunc_pl_level", int'(fifo_level), 520);
        for (int i = 0; i < 520; i++) rd_chk("trunc_drain_data");
        chk("trunc_drain_level", int'(fifo_level), 0);

        for (int i = 0; i < 972; i++) begin
            udp_rec_data_valid  = 1'b1;
            udp_rec_data_length = 16'd972;
            udp_rec_rdata       = pkt_byte(i, 8'h80, 16'd6, GOOD, 16'h0200);
            if (i == 112) rst_n = 1'b0;
            if (i == 115) rst_n = 1'b1;
            @(posedge clk); #1;
            if (i == 113) chk_all_zero("midrst");
        end
        udp_rec_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        chk_all_zero("postrst");

        send(972, 972, 8'h80, 16'd7, GOOD, 16'h0300);
        push_samples(16'h0300, 480);
        chk("after_rst_level", int'(fifo_level), 480);
        chk("after_rst_ok", int'(pkt_ok_cnt), 1);
        chk("after_rst_drop", int'(pkt_drop_cnt), 0);
        chk("after_rst_play", int'(playing), 1);
        rd_chk("after_rst_data");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
